// File: rtl/al_n2w_cnt_cfg_lim.sv
// Wrapping slice counter with a runtime limit.
// Counts 0..lim on inc, clears to 0 on clr (clr wins over inc).
module cnt_cfg_lim #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] cnt,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == lim) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign done_c = (cnt_q == lim);

endmodule

// File: rtl/al_n2w.sv
// Narrow-to-wide packer: gathers DAT_IN_W slices into a DAT_OUT_W word,
// closing early on us_last, with a single skid-free output register.
module al_n2w #(
  parameter int unsigned DAT_IN_W  = 8,
  parameter int unsigned DAT_OUT_W = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       us_vld,
  input  logic [DAT_IN_W-1:0]                        us_dat,
  input  logic                                       us_last,
  output logic                                       us_rdy,
  output logic                                       ds_vld,
  output logic [DAT_OUT_W-1:0]                       ds_dat,
  output logic [$clog2(DAT_OUT_W/DAT_IN_W)-1:0]      ds_last_vld_sel,
  output logic                                       ds_last,
  input  logic                                       ds_rdy
);

  localparam int unsigned N     = DAT_OUT_W / DAT_IN_W;
  localparam int unsigned SEL_W = $clog2(N);
  localparam logic [SEL_W-1:0] LIM = SEL_W'(N - 1);

  logic [SEL_W-1:0]     cnt;
  logic                 unused_cnt_done;
  logic                 accept;
  logic                 complete;
  logic [DAT_OUT_W-1:0] merged;

  logic [DAT_OUT_W-1:0] acc_q, acc_d;
  logic                 ds_vld_q, ds_vld_d;
  logic [DAT_OUT_W-1:0] ds_dat_q, ds_dat_d;
  logic [SEL_W-1:0]     ds_sel_q, ds_sel_d;
  logic                 ds_last_q, ds_last_d;

  assign us_rdy   = ~ds_vld_q | ds_rdy;
  assign accept   = us_vld & us_rdy;
  assign complete = accept & ((cnt == LIM) | us_last);

  cnt_cfg_lim #(
    .CNT_W (SEL_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (accept & ~complete),
    .clr    (complete),
    .lim    (LIM),
    .cnt    (cnt),
    .done_c (unused_cnt_done)
  );

  // Accumulator merged with the incoming slice; positions above cnt forced to zero.
  always_comb begin
    merged = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (SEL_W'(i) < cnt) begin
        merged[i*DAT_IN_W +: DAT_IN_W] = acc_q[i*DAT_IN_W +: DAT_IN_W];
      end else if (SEL_W'(i) == cnt) begin
        merged[i*DAT_IN_W +: DAT_IN_W] = us_dat;
      end
    end
  end

  always_comb begin
    acc_d     = acc_q;
    ds_vld_d  = ds_vld_q;
    ds_dat_d  = ds_dat_q;
    ds_sel_d  = ds_sel_q;
    ds_last_d = ds_last_q;
    if (complete) begin
      acc_d     = '0;
      ds_vld_d  = 1'b1;
      ds_dat_d  = merged;
      ds_sel_d  = cnt;
      ds_last_d = us_last;
    end else begin
      if (accept) begin
        acc_d = merged;
      end
      if (ds_vld_q & ds_rdy) begin
        ds_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      ds_vld_q  <= 1'b0;
      ds_dat_q  <= '0;
      ds_sel_q  <= '0;
      ds_last_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ds_vld_q  <= ds_vld_d;
      ds_dat_q  <= ds_dat_d;
      ds_sel_q  <= ds_sel_d;
      ds_last_q <= ds_last_d;
    end
  end

  assign ds_vld          = ds_vld_q;
  assign ds_dat          = ds_dat_q;
  assign ds_last_vld_sel = ds_sel_q;
  assign ds_last         = ds_last_q;

endmodule

// File: doc/al_n2w.md
AL_N2W -- requirements
Module: al_n2w

Interface
REQ-001 SHALL have parameter DAT_IN_W, default 8, narrow upstream slice width in bits.
REQ-002 SHALL have parameter DAT_OUT_W, default 32, wide downstream word width in bits; DAT_OUT_W % DAT_IN_W = 0 and DAT_OUT_W/DAT_IN_W a power of 2, at least 2.
REQ-003 SHALL derive localparams N = DAT_OUT_W/DAT_IN_W and SEL_W = clog2(N).
REQ-004 SHALL use one clock and an asynchronous active-high reset.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 us_vld  in  1  upstream slice valid.
REQ-008 us_dat  in  DAT_IN_W  upstream slice data.
REQ-009 us_last  in  1  slice closes the current word (packet end).
REQ-010 us_rdy  out  1  block accepts a slice this cycle.
REQ-011 ds_vld  out  1  wide word valid.
REQ-012 ds_dat  out  DAT_OUT_W  packed wide word.
REQ-013 ds_last_vld_sel  out  SEL_W  index of the last valid slice in ds_dat, 0-based.
REQ-014 ds_last  out  1  word was closed by us_last.
REQ-015 ds_rdy  in  1  downstream accepts the word.

Function
REQ-016 SHALL accept a slice when us_vld & us_rdy.
REQ-017 SHALL drive us_rdy = ~ds_vld | ds_rdy, combinational, independent of us_vld, us_dat and us_last.
REQ-018 SHALL keep a slice counter cnt (0..N-1) that selects the write position.
- An accepted slice is written to accumulator bits [cnt*DAT_IN_W +: DAT_IN_W].
REQ-019 SHALL treat an accepted slice as completing when cnt == N-1 or us_last == 1.
REQ-020 On a non-completing accept, SHALL increment cnt by 1.
REQ-021 On a completing accept, SHALL take these actions in the same edge:
- load the output register with the accumulator merged with the incoming slice;
- force slices above cnt to zero;
- set ds_last_vld_sel = cnt and ds_last = us_last;
- set ds_vld = 1;
- clear cnt to 0 and clear the accumulator to 0.
REQ-022 SHALL have a latency of one cycle: a completing slice accepted at edge t gives ds_vld = 1 and the word on ds_dat after edge t.
REQ-023 SHALL hold ds_dat, ds_last_vld_sel, ds_last and ds_vld stable while ds_vld & ~ds_rdy.
REQ-024 On ds_vld & ds_rdy with no completing accept at the same edge, SHALL clear ds_vld to 0.
REQ-025 If ds_vld & ds_rdy and a completing accept occur at the same edge, SHALL load the new word and keep ds_vld = 1, giving full throughput with no bubble.
REQ-026 While ds_vld & ~ds_rdy, us_rdy is 0 and SHALL leave cnt and the accumulator unchanged.
REQ-027 SHALL treat us_last on a slice at cnt == N-1 as one completion; ds_last = 1 and ds_last_vld_sel = N-1.
REQ-028 SHALL sustain one slice per cycle when ds_rdy is held at 1.
REQ-029 SHALL ignore us_dat and us_last when us_vld = 0.

Reset
REQ-030 While rst = 1, SHALL hold these values:
- ds_vld = 0, ds_dat = 0, ds_last_vld_sel = 0, ds_last = 0;
- cnt = 0 and accumulator = 0;
- us_rdy = 1.
REQ-031 SHALL discard a partially assembled word when rst is asserted mid-word, emit no output for it, and start at slice 0 after reset.
REQ-032 SHALL discard a held output word when rst is asserted, with no replay after reset.

Structure
REQ-033 SHALL place no typedefs in a shared package; the only parameters are DAT_IN_W and DAT_OUT_W.
REQ-034 SHALL implement the slice counter with the team's cnt_cfg_lim sub-module:
- CNT_W = SEL_W, lim = N-1;
- inc = non-completing accept;
- clr = completing accept.
- Its done output is not used for completion; completion follows REQ-019.
REQ-035 SHALL implement the rest as one accumulator register and one output register, with no further sub-modules.

Verification (DAT_IN_W = 8, DAT_OUT_W = 32)
REQ-036 Full word: slices 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles with ds_rdy = 1 -> one cycle after the 4th, ds_vld = 1, ds_dat = 0x44332211, ds_last_vld_sel = 3, ds_last = 0.
REQ-037 Early last: 0xAA, then 0xBB with us_last = 1 -> ds_dat = 0x0000BBAA, ds_last_vld_sel = 1, ds_last = 1; the next word starts at slice 0.
REQ-038 Backpressure: ds_rdy = 0 while a word is pending -> us_rdy = 0, outputs stable for 5 cycles; on ds_rdy = 1, the word is accepted once, us_rdy = 1 the same cycle, no data lost.
REQ-039 Streaming: 16 slices 0x00..0x0F back-to-back with ds_rdy = 1 -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive 4th cycles, no bubbles.
REQ-040 Reset mid-word: 2 slices accepted, rst pulsed -> ds_vld = 0; next slices 0x01..0x04 give ds_dat = 0x04030201.
REQ-041 Single-slice packet: 0x5A with us_last = 1 at cnt = 0 -> ds_dat = 0x0000005A, ds_last_vld_sel = 0, ds_last = 1.
